spi_master_ctrl: RTL and testbench

Parametrised SPI master transfer engine that replaces the fixed 16-edge control unit and its external pulse generator and shift registers. It holds an internal SCK divider, the TX/RX shift registers, all four CPOL/CPHA modes, N one-hot active-low chip selects and a start/busy/done handshake. It sits between the register interface (spi_reg) and the SPI pins.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_ctrl_if.sv | 43 ++++
 rtl/spi_clk_div.sv | 44 ++++
 rtl/spi_master_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer engine: one-hot FSM state
// encoding, SPI mode constants ({CPol, CPha}) and a chip-select width helper.
package spi_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_XFER  = 5'b00100,
    ST_HOLD  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Register-side bus of spi_master_ctrl: start/config/data in, result/status out.
// SPI_MASTER_LSB_FIRST_EN adds the LsbFirst bit-order select.
interface spi_master_ctrl_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CS   = 1,
  parameter int DIV_W  = 8,
  parameter int CS_W   = cs_width(N_CS)
);

  // StartTx is a level request: it is taken only while the engine is idle,
  // and Busy/EndTx report progress; there is no ready back-pressure.
  logic              StartTx;
  logic              CPol;
  logic              CPha;
  logic [DIV_W-1:0]  ClkDiv;
  logic [CS_W-1:0]   CsSel;
  logic [DATA_W-1:0] TxData;
  logic [DATA_W-1:0] RxData;
  logic              Busy;
  logic              EndTx;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              LsbFirst;
`endif

  modport master (
    output StartTx, CPol, CPha, ClkDiv, CsSel, TxData,
`ifdef SPI_MASTER_LSB_FIRST_EN
    output LsbFirst,
`endif
    input  RxData, Busy, EndTx
  );

  modport slave (
    input  StartTx, CPol, CPha, ClkDiv, CsSel, TxData,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  LsbFirst,
`endif
    output RxData, Busy, EndTx
  );

endinterface

// File: rtl/spi_clk_div.sv
// SCK divider: counts ClkDiv+1 cycles per tick while enabled and toggles the
// SCK phase on each tick when toggling is enabled; SCK = idle level ^ phase.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             CntEn,
  input  logic             TglEn,
  input  logic [DIV_W-1:0] Div,
  input  logic             IdleLvl,
  output logic             Tick,
  output logic             Sck
);

  logic [DIV_W-1:0] cnt_q;
  logic             phase_q;

  assign Tick = CntEn && (cnt_q == Div);
  assign Sck  = IdleLvl ^ phase_q;

  // Clearing on every tick also zeroes the count on each FSM state entry,
  // since all timed states are left on a tick.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (!CntEn || Tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase_q <= 1'b0;
    end else if (!TglEn) begin
      phase_q <= 1'b0;
    end else if (Tick) begin
      phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer engine: all four CPOL/CPHA modes, internal SCK divider,
// one-hot active-low chip selects. SPI_MASTER_LSB_FIRST_EN adds LSB-first order.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CS   = 1,
  parameter int DIV_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  spi_master_ctrl_if.slave  Bus,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [N_CS-1:0]   CS_n,
  output state_e            DbgState
);

  localparam int CS_W = cs_width(N_CS);
  localparam int EC_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);
  localparam logic [CS_W:0]   N_CS_L    = (CS_W + 1)'(N_CS);

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [CS_W-1:0]   cs_q;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
  logic [EC_W-1:0]   edge_q;
  logic              started_q;
  logic              lsb_first;
  logic              tick, cnt_en, start_acc, edge_tick, leading, last_edge;
  logic              sample_lead, do_sample, do_shift;
  logic [CS_W-1:0]   cs_idx;
  logic [DATA_W-1:0] tx_next, rx_next;

  assign start_acc   = (state_q == ST_IDLE) && Bus.StartTx;
  assign cnt_en      = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
  assign edge_tick   = (state_q == ST_XFER) && tick;
  assign leading     = ~edge_q[0];
  assign last_edge   = (edge_q == LAST_EDGE);
  assign sample_lead = (mode_q == MODE0) || (mode_q == MODE2);
  assign do_sample   = edge_tick && (leading == sample_lead);
  // CPha=0 skips the shift on the final trailing edge; CPha=1 re-drives the
  // MSB (already on MOSI since SETUP) on the first leading edge.
  assign do_shift    = edge_tick && !do_sample &&
                       (sample_lead ? !last_edge : (edge_q != '0));
  assign cs_idx      = ({1'b0, Bus.CsSel} < N_CS_L) ? Bus.CsSel : '0;

`ifdef SPI_MASTER_LSB_FIRST_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lsb_first <= 1'b0;
    end else if (start_acc) begin
      lsb_first <= Bus.LsbFirst;
    end
  end
`else
  assign lsb_first = 1'b0;
`endif

  assign tx_next = lsb_first ? {1'b0, tx_sr[DATA_W-1:1]} : {tx_sr[DATA_W-2:0], 1'b0};
  assign rx_next = lsb_first ? {MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], MISO};
  assign MOSI    = lsb_first ? tx_sr[0] : tx_sr[DATA_W-1];

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .CntEn   (cnt_en),
    .TglEn   (state_q == ST_XFER),
    .Div     (div_q),
    .IdleLvl (mode_q[1]),
    .Tick    (tick),
    .Sck     (SCK)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Bus.StartTx)       state_d = ST_SETUP;
      ST_SETUP: if (tick)              state_d = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (tick)              state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CS_n       = '1;
    Bus.Busy   = cnt_en;
    Bus.EndTx  = (state_q == ST_DONE);
    Bus.RxData = rx_data_q;
    DbgState   = state_q;
    if (cnt_en) begin
      for (int i = 0; i < N_CS; i++) begin
        if (cs_q == CS_W'(i)) CS_n[i] = 1'b0;
      end
    end
  end

  // Before the first start the idle SCK level tracks the CPol input.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q    <= MODE0;
      div_q     <= '0;
      cs_q      <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      started_q <= 1'b0;
    end else begin
      if (start_acc) begin
        mode_q    <= {Bus.CPol, Bus.CPha};
        div_q     <= Bus.ClkDiv;
        cs_q      <= cs_idx;
        tx_sr     <= Bus.TxData;
        rx_sr     <= '0;
        started_q <= 1'b1;
      end else if ((state_q == ST_IDLE) && !started_q) begin
        mode_q[1] <= Bus.CPol;
      end
      if (do_shift)  tx_sr <= tx_next;
      if (do_sample) rx_sr <= rx_next;
      if ((state_q == ST_HOLD) && tick) rx_data_q <= rx_sr;
      if (state_q != ST_XFER) begin
        edge_q <= '0;
      end else if (tick) begin
        edge_q <= edge_q + EC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (DATA_W=8, N_CS=5 so CsSel can exceed the
// CS count): loopback and slave-model transfers, RxData scoreboard queue.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int DATA_W = 8;
  localparam int N_CS   = 5;
  localparam int DIV_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck, mosi, miso;
  logic [N_CS-1:0] cs_n;
  state_e dbg;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  // slave model on CS_n[0] (used when loop_en=0)
  logic       loop_en = 1'b1;
  logic       slave_cpha = 1'b0;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] s_sr = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       slave_miso = 1'b0;
  int         s_cnt = 0;
  logic       s_cs_prev = 1'b0, s_sck_prev = 1'b0;

  // pin monitor
  int   cs_bad = 0, sck_rise = 0, sck_edges = 0, end_cnt = 0;
  int   cs_low[N_CS] = '{default: 0};
  logic m_sck_prev = 1'b0, m_cs_prev = 1'b0, m_cs_act;

  spi_master_ctrl_if #(.DATA_W(DATA_W), .N_CS(N_CS), .DIV_W(DIV_W)) bus ();

  spi_master_ctrl #(.DATA_W(DATA_W), .N_CS(N_CS), .DIV_W(DIV_W)) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Bus      (bus),
    .SCK      (sck),
    .MOSI     (mosi),
    .MISO     (miso),
    .CS_n     (cs_n),
    .DbgState (dbg)
  );

  assign miso = loop_en ? mosi : slave_miso;

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    m_cs_act = (cs_n != '1);
    if (rst_n) begin
      if (!$onehot0(~cs_n)) cs_bad++;
      for (int i = 0; i < N_CS; i++) if (!cs_n[i]) cs_low[i]++;
      if (m_cs_act && m_cs_prev && (sck != m_sck_prev)) sck_edges++;
      if (m_cs_act && m_cs_prev && sck && !m_sck_prev) sck_rise++;
      if (bus.EndTx) end_cnt++;
    end
    m_sck_prev = sck;
    m_cs_prev  = m_cs_act;
  end

  // Slave: MSB-first, samples MOSI on its sample edge, drives MISO on the other.
  always @(negedge clk) begin
    if (!cs_n[0] && !s_cs_prev) begin
      s_sr = slave_word;
      slave_miso = s_sr[7];
      s_cnt = 0;
      s_rx = 8'h00;
    end else if (!cs_n[0] && s_cs_prev && (sck != s_sck_prev)) begin
      s_cnt++;
      if (s_cnt[0] != slave_cpha) begin
        s_rx = {s_rx[6:0], mosi};
      end else if (!(slave_cpha && s_cnt == 1)) begin
        s_sr = {s_sr[6:0], 1'b0};
        slave_miso = s_sr[7];
      end
    end
    s_cs_prev  = !cs_n[0];
    s_sck_prev = sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one full transfer with pulses of StartTx optionally injected
  task automatic run_xfer(input logic cpol, input logic cpha, input logic [7:0] div,
                          input logic [2:0] cs, input logic [7:0] tx, input logic lsb,
                          input logic [7:0] exp_rx, input logic pulse, input string tag);
    int cyc, e0, r0, lat, cs_eff;
    int l0[N_CS];
    logic [N_CS-1:0] low_mask;
    logic [N_CS-1:0] exp_mask;
    #1;
    e0 = end_cnt;
    r0 = sck_rise;
    l0 = cs_low;
    cs_eff = (int'(cs) < N_CS) ? int'(cs) : 0;
    @(negedge clk);
    bus.CPol = cpol;
    bus.CPha = cpha;
    bus.ClkDiv = div;
    bus.CsSel = cs;
    bus.TxData = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.LsbFirst = lsb;
`endif
    bus.StartTx = 1'b1;
    exp_q.push_back(exp_rx);
    @(negedge clk);
    bus.StartTx = 1'b0;
    check({tag, "_busy_setup"}, bus.Busy, 1'b1);
    check({tag, "_sck_setup"}, sck, cpol);
    check({tag, "_mosi_first"}, mosi, lsb ? tx[0] : tx[7]);
    cyc = 1;
    while (!bus.EndTx && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.StartTx = pulse && (cyc == 5 || cyc == 10);
    end
    bus.StartTx = 1'b0;
    lat = (int'(div) + 1) * (2 * DATA_W + 2) + 1;
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busy_done"}, bus.Busy, 1'b0);
    if (exp_q.size() > 0) check({tag, "_rxdata"}, bus.RxData, exp_q.pop_front());
    @(negedge clk);
    #1;
    for (int i = 0; i < N_CS; i++) low_mask[i] = (cs_low[i] != l0[i]);
    exp_mask = '0;
    exp_mask[cs_eff] = 1'b1;
    check({tag, "_endtx_count"}, end_cnt - e0, 1);
    check({tag, "_sck_rises"}, sck_rise - r0, DATA_W);
    check({tag, "_cs_mask"}, low_mask, exp_mask);
    check({tag, "_cs_onehot"}, cs_bad, 0);
    check({tag, "_idle_after"}, dbg, ST_IDLE);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int e0, ed0, k;
    logic [1:0] m;
    logic [7:0] d, t;
    logic [2:0] c;
    bus.StartTx = 1'b0;
    bus.CPol = 1'b1;
    bus.CPha = 1'b0;
    bus.ClkDiv = '0;
    bus.CsSel = '0;
    bus.TxData = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.LsbFirst = 1'b0;
`endif

    // reset state (CPol=1 must not leak onto SCK during reset)
    #12;
    check("rst_sck", sck, 1'b0);
    check("rst_cs_n", cs_n, 5'h1f);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_endtx", bus.EndTx, 1'b0);
    check("rst_rxdata", bus.RxData, 8'h00);
    check("rst_state", dbg, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(2);
    check("idle_sck_follows_cpol", sck, 1'b1);
    bus.CPol = 1'b0;
    wait_neg(2);
    check("idle_sck_cpol0", sck, 1'b0);

    // mode 0 loopback
    run_xfer(1'b0, 1'b0, 8'd1, 3'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, "m0");

    // mode 3 against slave model
    loop_en = 1'b0;
    slave_cpha = 1'b1;
    slave_word = 8'h3C;
    run_xfer(1'b1, 1'b1, 8'd0, 3'd0, 8'hC3, 1'b0, 8'h3C, 1'b0, "m3");
    check("m3_slave_rx", s_rx, 8'hC3);
    wait_neg(2);
    check("m3_sck_idle_after", sck, 1'b1);
    loop_en = 1'b1;

    // chip-select routing, including out-of-range indices
    run_xfer(1'b0, 1'b0, 8'd0, 3'd2, 8'h3E, 1'b0, 8'h3E, 1'b0, "cs2");
    run_xfer(1'b0, 1'b1, 8'd0, 3'd5, 8'h81, 1'b0, 8'h81, 1'b0, "cs5");
    run_xfer(1'b1, 1'b0, 8'd0, 3'd7, 8'h5B, 1'b0, 8'h5B, 1'b0, "cs7");

    // StartTx pulses while busy are dropped
    run_xfer(1'b0, 1'b0, 8'd1, 3'd1, 8'h96, 1'b0, 8'h96, 1'b1, "pulse");
    wait_neg(4);
    check("pulse_no_restart_busy", bus.Busy, 1'b0);
    check("pulse_no_restart_state", dbg, ST_IDLE);

    // random loopback transfers
    for (int i = 0; i < 4; i++) begin
      m = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 3));
      t = 8'($urandom_range(0, 255));
      c = 3'($urandom_range(0, 4));
      run_xfer(m[1], m[0], d, c, t, 1'b0, t, 1'b0, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a mode-2 transfer at edge 7
    e0 = end_cnt;
    ed0 = sck_edges;
    @(negedge clk);
    bus.CPol = 1'b1;
    bus.CPha = 1'b0;
    bus.ClkDiv = 8'd1;
    bus.CsSel = 3'd0;
    bus.TxData = 8'h5A;
    bus.StartTx = 1'b1;
    @(negedge clk);
    bus.StartTx = 1'b0;
    k = 0;
    while ((sck_edges - ed0) < 7 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_reached_edge7", sck_edges - ed0, 7);
    rst_n = 1'b0;
    #1;
    check("abort_sck", sck, 1'b0);
    check("abort_cs_n", cs_n, 5'h1f);
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_endtx", bus.EndTx, 1'b0);
    check("abort_rxdata", bus.RxData, 8'h00);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(5);
    check("abort_no_endtx", end_cnt - e0, 0);
    check("abort_sck_idle", sck, 1'b1);
    run_xfer(1'b1, 1'b0, 8'd1, 3'd0, 8'h69, 1'b0, 8'h69, 1'b0, "after_abort");

`ifdef SPI_MASTER_LSB_FIRST_EN
    run_xfer(1'b0, 1'b0, 8'd1, 3'd0, 8'h01, 1'b1, 8'h01, 1'b0, "lsb01");
    run_xfer(1'b1, 1'b1, 8'd0, 3'd3, 8'hB4, 1'b1, 8'hB4, 1'b0, "lsbB4");
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
